// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Holds the pipeline stalled while a result is pending, and keeps the old HI/LO visible until the result is written.
//
//  state | meaning
//  IDLE  | accepting MDU requests; MTHI/MTLO write immediately
//  RUN   | result computed and latched, counting down to the HI/LO write
module mdu_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        abort,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       pendHi;
    logic [31:0]       pendLo;

    logic              isMdOp;
    logic              isDivOp;
    logic              oneShot;
    logic [CNT_W-1:0]  loadCnt;
    logic              divZero;
    logic              divOvf;
    logic signed [31:0] bSafeS;
    logic [31:0]       bSafeU;
    logic signed [31:0] quotS;
    logic signed [31:0] remS;
    logic [31:0]       quotU;
    logic [31:0]       remU;
    logic signed [63:0] mulS;
    logic [63:0]       mulU;
    logic [63:0]       calcRes;

    assign isMdOp    = (op >= OP_MULT) && (op <= OP_DIVU);
    assign isDivOp   = (op == OP_DIV) || (op == OP_DIVU);
    assign oneShot   = isDivOp ? (DIV_CYCLES == 1) : (MULT_CYCLES == 1);
    assign loadCnt   = isDivOp ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
    assign stall_req = busy | (start & isMdOp & ~abort);

    // Divisor is forced to 1 for the special cases so the divider never sees /0 or INT_MIN/-1.
    always_comb begin
        divZero = (B == 32'd0);
        divOvf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        bSafeS  = (divZero || divOvf) ? 32'sd1 : $signed(B);
        bSafeU  = divZero ? 32'd1 : B;
        quotS   = $signed(A) / bSafeS;
        remS    = $signed(A) % bSafeS;
        quotU   = A / bSafeU;
        remU    = A % bSafeU;
        mulS    = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        mulU    = {32'd0, A} * {32'd0, B};
        calcRes = 64'd0;
        case (op)
            OP_MULT:  calcRes = mulS;
            OP_MULTU: calcRes = mulU;
            OP_DIV: begin
                if (divZero)     calcRes = {A, 32'hFFFF_FFFF};
                else if (divOvf) calcRes = {32'd0, 32'h8000_0000};
                else             calcRes = {remS, quotS};
            end
            OP_DIVU: begin
                if (divZero) calcRes = {A, 32'hFFFF_FFFF};
                else         calcRes = {remU, quotU};
            end
            default:  calcRes = 64'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            HI     <= 32'd0;
            LO     <= 32'd0;
            pendHi <= 32'd0;
            pendLo <= 32'd0;
        end else if (abort) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (isMdOp) begin
                            if (oneShot) begin
                                HI <= calcRes[63:32];
                                LO <= calcRes[31:0];
                            end else begin
                                pendHi <= calcRes[63:32];
                                pendLo <= calcRes[31:0];
                                cnt    <= loadCnt;
                                busy   <= 1'b1;
                                state  <= RUN;
                            end
                        end else if (op == OP_MTHI) begin
                            HI <= A;
                        end else if (op == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    // Terminal count is the edge where the decrement lands on zero, i.e. N-1 edges after accept.
                    if (cnt == CNT_W'(1)) begin
                        HI    <= pendHi;
                        LO    <= pendLo;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: arithmetic results, busy/stall timing, MTHI/MTLO, abort and reset behaviour.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mdu_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] A     = 32'd0;
    logic [31:0] B     = 32'd0;
    logic        abort = 1'b0;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    int vectors = 0;
    int miscompares = 0;

    mdu_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .abort     (abort),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clock = ~clock;

    // Present a one-cycle request; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; op = 3'd0; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 50) begin
            cyc++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if (busy !== 1'b0 || stall_req !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b stall=%b HI=%h LO=%h, want 0 0 0 0", busy, stall_req, HI, LO);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_mult;
        int cyc;
        start = 1'b1; op = 3'd1; A = 32'hFFFF_FFFE; B = 32'd3;
        #1;
        vectors++;
        if (stall_req !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mult_start_stall: stall=%b busy=%b, want 1 0", stall_req, busy);
        end
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        vectors++;
        if (busy !== 1'b1 || HI !== 32'd0 || LO !== 32'd0) begin
            miscompares++;
            $display("FAIL mult_in_flight: busy=%b HI=%h LO=%h, want 1 0 0", busy, HI, LO);
        end
        wait_idle(cyc);
        vectors++;
        if (cyc != 4) begin
            miscompares++;
            $display("FAIL mult_busy_cycles: got %0d, want 4", cyc);
        end
        vectors++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA || stall_req !== 1'b0) begin
            miscompares++;
            $display("FAIL mult_result: HI=%h LO=%h stall=%b, want ffffffff fffffffa 0", HI, LO, stall_req);
        end
    endtask

    task automatic test_multu;
        int cyc;
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(cyc);
        vectors++;
        if (cyc != 4 || HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL multu: cyc=%0d HI=%h LO=%h, want 4 fffffffe 00000001", cyc, HI, LO);
        end
    endtask

    task automatic test_div;
        int cyc;
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        vectors++;
        if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL div_hold_old: HI=%h LO=%h, want fffffffe 00000001", HI, LO);
        end
        wait_idle(cyc);
        vectors++;
        if (cyc != 9 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("FAIL div_neg7_2: cyc=%0d HI=%h LO=%h, want 9 ffffffff fffffffd", cyc, HI, LO);
        end
        issue(3'd3, 32'd7, 32'hFFFF_FFFE);
        wait_idle(cyc);
        vectors++;
        if (HI !== 32'd1 || LO !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("FAIL div_7_neg2: HI=%h LO=%h, want 00000001 fffffffd", HI, LO);
        end
        issue(3'd4, 32'd7, 32'd0);
        wait_idle(cyc);
        vectors++;
        if (cyc != 9 || HI !== 32'd7 || LO !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL divu_by_zero: cyc=%0d HI=%h LO=%h, want 9 00000007 ffffffff", cyc, HI, LO);
        end
        issue(3'd4, 32'd100, 32'd7);
        wait_idle(cyc);
        vectors++;
        if (HI !== 32'd2 || LO !== 32'd14) begin
            miscompares++;
            $display("FAIL divu_100_7: HI=%h LO=%h, want 00000002 0000000e", HI, LO);
        end
    endtask

    task automatic test_overflow_mtlo;
        int cyc;
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        vectors++;
        if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL div_overflow: HI=%h LO=%h, want 00000000 80000000", HI, LO);
        end
        start = 1'b1; op = 3'd6; A = 32'h1234;
        #1;
        vectors++;
        if (stall_req !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo_stall: stall=%b, want 0", stall_req);
        end
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; op = 3'd0;
        vectors++;
        if (LO !== 32'h1234 || HI !== 32'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo: LO=%h HI=%h busy=%b, want 00001234 00000000 0", LO, HI, busy);
        end
    endtask

    task automatic test_abort;
        issue(3'd5, 32'hAAAA_AAAA, 32'd0);
        issue(3'd6, 32'h5555_5555, 32'd0);
        vectors++;
        if (HI !== 32'hAAAA_AAAA || LO !== 32'h5555_5555 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi_mtlo: HI=%h LO=%h busy=%b, want aaaaaaaa 55555555 0", HI, LO, busy);
        end
        issue(3'd4, 32'd100, 32'd7);
        @(negedge clock);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || HI !== 32'hAAAA_AAAA || LO !== 32'h5555_5555) begin
            miscompares++;
            $display("FAIL abort_run: busy=%b HI=%h LO=%h, want 0 aaaaaaaa 55555555", busy, HI, LO);
        end
        repeat (12) @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || HI !== 32'hAAAA_AAAA || LO !== 32'h5555_5555) begin
            miscompares++;
            $display("FAIL abort_no_late_write: busy=%b HI=%h LO=%h, want 0 aaaaaaaa 55555555", busy, HI, LO);
        end
        abort = 1'b1; start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd3;
        #1;
        vectors++;
        if (stall_req !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_start_stall: stall=%b, want 0", stall_req);
        end
        @(posedge clock);
        @(negedge clock);
        op = 3'd5; A = 32'h7777_7777;
        @(posedge clock);
        @(negedge clock);
        abort = 1'b0; start = 1'b0; op = 3'd0;
        repeat (6) @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || HI !== 32'hAAAA_AAAA || LO !== 32'h5555_5555) begin
            miscompares++;
            $display("FAIL abort_blocks_start: busy=%b HI=%h LO=%h, want 0 aaaaaaaa 55555555", busy, HI, LO);
        end
    endtask

    task automatic test_ignore_in_run;
        int cyc;
        issue(3'd1, 32'd6, 32'd7);
        @(negedge clock);
        start = 1'b1; op = 3'd5; A = 32'h0000_DEAD;
        @(negedge clock);
        op = 3'd1; A = 32'd100; B = 32'd100;
        @(negedge clock);
        start = 1'b0; op = 3'd0;
        wait_idle(cyc);
        vectors++;
        if (HI !== 32'd0 || LO !== 32'd42) begin
            miscompares++;
            $display("FAIL run_ignores_start: HI=%h LO=%h, want 00000000 0000002a", HI, LO);
        end
        repeat (8) @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd42) begin
            miscompares++;
            $display("FAIL run_no_second_op: busy=%b HI=%h LO=%h, want 0 0 2a", busy, HI, LO);
        end
    endtask

    task automatic test_reset_mid_run;
        issue(3'd2, 32'd5, 32'd9);
        @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || stall_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_run: busy=%b HI=%h LO=%h stall=%b, want 0 0 0 0", busy, HI, LO, stall_req);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (8) @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_no_pending: busy=%b HI=%h LO=%h, want 0 0 0", busy, HI, LO);
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_multu;
        test_div;
        test_overflow_mtlo;
        test_abort;
        test_ignore_in_run;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
